// File: rtl/dft_sample_streamer_if.sv
// dft_sample_streamer_if: valid/ready sample stream carrying word, buffer index and last flag
interface dft_sample_streamer_if #(parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [3:0]        idx;
  logic              last;
  modport master (output valid, data, idx, last, input ready);
  modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/dft_sample_streamer.sv
// dft_sample_streamer: snapshots 16 selector words and streams them one per beat; BITREV_ORDER_EN selects bit-reversed order
module dft_sample_streamer #(parameter int DATA_W = 32) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_pattern_sel,
  output logic [2:0]            o_k_sel,
  input  logic [DATA_W-1:0]     i_x [16],
  output logic                  o_busy,
  output logic                  o_done,
  dft_sample_streamer_if.master m_out
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t            r_state, w_next;
  logic [3:0]        r_beat, w_idx;
  logic [2:0]        r_k_sel;
  logic [DATA_W-1:0] r_buf [16];
  logic              w_fire;
  assign w_fire  = (r_state == STREAM) && m_out.ready;
  assign o_k_sel = r_k_sel;
`ifdef BITREV_ORDER_EN
  assign w_idx = {r_beat[0], r_beat[1], r_beat[2], r_beat[3]};
`else
  assign w_idx = r_beat;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state and stream outputs, all decoded from registers
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && i_start) w_next = LOAD;
    if (r_state == LOAD) w_next = STREAM;
    if (w_fire && r_beat == 4'd15) w_next = DONE;
    if (r_state == DONE) w_next = IDLE;
    o_busy      = (r_state == LOAD) || (r_state == STREAM);
    o_done      = r_state == DONE;
    m_out.valid = r_state == STREAM;
    m_out.idx   = w_idx;
    m_out.data  = m_out.valid ? r_buf[w_idx] : '0;
    m_out.last  = m_out.valid && r_beat == 4'd15;
  end
  // select latch, snapshot buffer and beat counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_k_sel <= '0;
      r_beat  <= '0;
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_k_sel <= i_pattern_sel;
        r_beat  <= '0;
      end
      if (r_state == LOAD) r_buf <= i_x;
      if (w_fire) r_beat <= r_beat + 4'd1;
    end
endmodule
